assoc_cache_ctrl: RTL and testbench

//  Parametrised 2-way set-associative, write-back, write-allocate cache sitting between the CPU and word-wide RAM.

---
 rtl/assoc_cache_ctrl_if.sv | 32 +++
 rtl/assoc_cache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_ctrl_if.sv
// CPU-side and RAM-side signal bundle for the 2-way set-associative cache controller.
// The cache uses the slave view; the requester/RAM model uses the master view.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, mem_req, mem_rw, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, mem_req, mem_rw, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-back, write-allocate cache controller with per-set LRU,
// multi-word line bursts to word-wide RAM and saturating hit/miss counters.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | waiting for cpu_req; request fields latched on accept
//  S_LOOKUP    | tag compare; hit completes access, miss picks a victim
//  S_WRITEBACK | streaming dirty victim line out to RAM, one word per mem_ready
//  S_REFILL    | streaming requested line in from RAM, then replay LOOKUP
module assoc_cache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 10,
  parameter int OFFSET_W = 1,
  parameter int INDEX_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  assoc_cache_ctrl_if.slave   bus
);
  localparam int WPL   = 1 << OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL} state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                replay_q, replay_d;
  logic                victim_q, victim_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     valid_d [2];
  logic [SETS-1:0]     dirty_q [2];
  logic [SETS-1:0]     dirty_d [2];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [TAG_W-1:0]    tag_q [2][SETS];
  logic [TAG_W-1:0]    tag_d [2][SETS];
  logic [DATA_W-1:0]   data_q [2][SETS][WPL];
  logic [DATA_W-1:0]   data_d [2][SETS][WPL];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit0, hit1, hit, hit_way, miss_victim;

  assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx = addr_q[OFFSET_W +: INDEX_W];
  assign req_off = addr_q[OFFSET_W-1:0];

  assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  // Fill empty ways in order before evicting the least recently used one.
  assign miss_victim = !valid_q[0][req_idx] ? 1'b0 :
                       !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    replay_d   = replay_q;
    victim_d   = victim_q;
    cnt_d      = cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    tag_d      = tag_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          rw_d    = bus.cpu_rw;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        replay_d = 1'b0;
        if (hit) begin
          if (rw_q) begin
            data_d[hit_way][req_idx][req_off] = wdata_q;
            dirty_d[hit_way][req_idx]         = 1'b1;
          end
          lru_d[req_idx] = ~hit_way;
          if (!replay_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          state_d = S_IDLE;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          cnt_d    = '0;
          victim_d = miss_victim;
          state_d  = (valid_q[miss_victim][req_idx] && dirty_q[miss_victim][req_idx])
                     ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        // cnt wraps to zero on the last word, ready for the refill burst.
        if (bus.mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_ready) begin
          data_d[victim_q][req_idx][cnt_q] = bus.mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            tag_d[victim_q][req_idx]   = req_tag;
            valid_d[victim_q][req_idx] = 1'b1;
            dirty_d[victim_q][req_idx] = 1'b0;
            replay_d                   = 1'b1;
            state_d                    = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      replay_q   <= 1'b0;
      victim_q   <= 1'b0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      lru_q      <= '0;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s] <= '0;
          for (int o = 0; o < WPL; o++) data_q[w][s][o] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      replay_q   <= replay_d;
      victim_q   <= victim_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      lru_q      <= lru_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  // Outputs decode straight from state so reset drops mem_req without a clock.
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_req   = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      S_LOOKUP: begin
        if (hit) begin
          bus.cpu_ready = 1'b1;
          if (!rw_q) bus.cpu_rdata = data_q[hit_way][req_idx][req_off];
        end
      end
      S_WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = {tag_q[victim_q][req_idx], req_idx, cnt_q};
        bus.mem_wdata = data_q[victim_q][req_idx][cnt_q];
      end
      S_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_idx, cnt_q};
      end
      default: ;
    endcase
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Bench for assoc_cache_ctrl: table of CPU accesses with a RAM model and read-data scoreboard,
// plus hand sequences for stalled bursts and reset in the middle of a refill.
module tb_assoc_cache_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(1), .INDEX_W(4), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          rw;
    logic [9:0]  addr;
    logic [9:0]  data;
  } xfer_t;
  xfer_t      log_q [$];
  logic [9:0] exp_q [$];

  typedef struct {
    bit rw;
    int addr, wdata, rdata, lat, nwr, wr_base, wd0, nrd, rd_base, hits, miss;
  } vec_t;
  vec_t vecs [12];

  function automatic int mv(int a);
    return (a * 37 + 11) & 1023;
  endfunction

  // RAM model: untouched words hold mv(addr); written words remembered.
  bit [9:0] mem_ovr [1024];
  bit       mem_w   [1024];
  bit       toggle_mode = 1'b0;
  logic     ready_ph = 1'b1;

  assign bus.mem_ready = ready_ph;
  assign bus.mem_rdata = !bus.mem_ready ? 10'd0 :
                         mem_w[bus.mem_addr] ? mem_ovr[bus.mem_addr] : 10'(mv(32'(bus.mem_addr)));

  always @(posedge clk) ready_ph <= toggle_mode ? ~ready_ph : 1'b1;

  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ready) begin
      log_q.push_back(xfer_t'{bus.mem_rw, bus.mem_addr, bus.mem_rw ? bus.mem_wdata : bus.mem_rdata});
      if (bus.mem_rw) begin
        mem_ovr[bus.mem_addr] <= bus.mem_wdata;
        mem_w[bus.mem_addr]   <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rw, int addr, int wdata, int rdata, int lat, int nwr,
                              int wr_base, int wd0, int nrd, int rd_base, int hits, int miss);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.nwr = nwr;
    v.wr_base = wr_base; v.wd0 = wd0; v.nrd = nrd; v.rd_base = rd_base; v.hits = hits; v.miss = miss;
    return v;
  endfunction

  task automatic pop_rdata(input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, " rdata"}, 32'(bus.cpu_rdata), 32'(e));
    end
  endtask

  // Drive one access at a negedge with the DUT idle; returns cycles from acceptance to cpu_ready.
  task automatic do_access(input bit rw, input int addr, input int wdata, input int exp_rd,
                           input string name, output int lat);
    log_q.delete();
    if (!rw) exp_q.push_back(10'(exp_rd));
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = 10'(addr);
    bus.cpu_wdata = 10'(wdata);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) break;
      check({name, " rdata idle zero"}, 32'(bus.cpu_rdata), 0);
      if (lat >= 60) begin
        check({name, " cpu_ready timeout"}, 0, 1);
        break;
      end
    end
    if (bus.cpu_ready && !rw) pop_rdata(name);
  endtask

  task automatic check_log(input string name, input int nwr, input int wr_base, input int wd0,
                           input int nrd, input int rd_base);
    int nw = 0;
    int nr = 0;
    check({name, " burst words"}, log_q.size(), nwr + nrd);
    foreach (log_q[k]) begin
      check({name, " burst order"}, int'(log_q[k].rw), (k < nwr) ? 1 : 0);
      if (log_q[k].rw) begin
        check({name, " wb addr"}, 32'(log_q[k].addr), wr_base + nw);
        if (nw == 0) check({name, " wb data0"}, 32'(log_q[k].data), wd0);
        nw++;
      end else begin
        check({name, " refill addr"}, 32'(log_q[k].addr), rd_base + nr);
        nr++;
      end
    end
  endtask

  task automatic check_counts(input string name, input int hits, input int miss);
    check({name, " hit_count"}, 32'(bus.hit_count), hits);
    check({name, " miss_count"}, 32'(bus.miss_count), miss);
  endtask

  // Access with mem_ready alternating; checks bus stability during stall cycles.
  task automatic toggled_access(input int addr, input int exp_rd, input int nwr, input int wr_base,
                                input int wd0, input int wd1, input int rd_base, input string name);
    bit         have_prev = 1'b0;
    bit         prev_ready = 1'b1;
    logic [9:0] prev_addr = '0;
    logic [9:0] prev_wd = '0;
    bit         prev_rw = 1'b0;
    int         stalls = 0;
    int         lat = 0;
    log_q.delete();
    exp_q.push_back(10'(exp_rd));
    toggle_mode   = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 10'(addr);
    bus.cpu_wdata = '0;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) break;
      if (bus.mem_req) begin
        if (have_prev && !prev_ready) begin
          stalls++;
          check({name, " stall addr"}, 32'(bus.mem_addr), 32'(prev_addr));
          check({name, " stall rw"}, int'(bus.mem_rw), int'(prev_rw));
          if (bus.mem_rw) check({name, " stall wdata"}, 32'(bus.mem_wdata), 32'(prev_wd));
        end
        have_prev  = 1'b1;
        prev_ready = bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_wd    = bus.mem_wdata;
        prev_rw    = bus.mem_rw;
      end else begin
        have_prev = 1'b0;
      end
      if (lat >= 80) begin
        check({name, " cpu_ready timeout"}, 0, 1);
        break;
      end
    end
    if (bus.cpu_ready) pop_rdata(name);
    toggle_mode = 1'b0;
    check({name, " saw stalls"}, int'(stalls > 0), 1);
    check_log(name, nwr, wr_base, wd0, 2, rd_base);
    if (nwr == 2 && log_q.size() > 1) check({name, " wb data1"}, 32'(log_q[1].data), wd1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit seen;
    bus.cpu_req   = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    vecs[0]  = mk(1, 50, 300, 0,       4, 0, 0,  0,   2, 50,  0, 1);
    vecs[1]  = mk(0, 50, 0,   300,     1, 0, 0,  0,   0, 0,   1, 1);
    vecs[2]  = mk(0, 82, 0,   mv(82),  4, 0, 0,  0,   2, 82,  1, 2);
    vecs[3]  = mk(0, 50, 0,   300,     1, 0, 0,  0,   0, 0,   2, 2);
    vecs[4]  = mk(0, 114, 0,  mv(114), 4, 0, 0,  0,   2, 114, 2, 3);
    vecs[5]  = mk(0, 82, 0,   mv(82),  6, 2, 50, 300, 2, 82,  2, 4);
    vecs[6]  = mk(0, 51, 0,   mv(51),  4, 0, 0,  0,   2, 50,  2, 5);
    vecs[7]  = mk(0, 50, 0,   300,     1, 0, 0,  0,   0, 0,   3, 5);
    vecs[8]  = mk(1, 0,  5,   0,       4, 0, 0,  0,   2, 0,   3, 6);
    vecs[9]  = mk(0, 0,  0,   5,       1, 0, 0,  0,   0, 0,   4, 6);
    vecs[10] = mk(0, 1,  0,   mv(1),   1, 0, 0,  0,   0, 0,   5, 6);
    vecs[11] = mk(1, 83, 77,  0,       1, 0, 0,  0,   0, 0,   6, 6);

    #2;
    check("reset cpu_ready", int'(bus.cpu_ready), 0);
    check("reset cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("reset mem_req", int'(bus.mem_req), 0);
    check("reset mem_rw", int'(bus.mem_rw), 0);
    check("reset mem_addr", 32'(bus.mem_addr), 0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 0);
    check_counts("reset", 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, nm, lat);
      check({nm, " latency"}, lat, vecs[i].lat);
      check_log(nm, vecs[i].nwr, vecs[i].wr_base, vecs[i].wd0, vecs[i].nrd, vecs[i].rd_base);
      @(negedge clk);
      check_counts(nm, vecs[i].hits, vecs[i].miss);
    end

    // idx9 now: way0 = 82 dirty (83=77), way1 = 50 clean, LRU -> way1.
    toggled_access(114, mv(114), 0, 0, 0, 0, 114, "tog clean");
    check_counts("tog clean", 6, 7);
    toggled_access(50, 300, 2, 82, mv(82), 77, 50, "tog dirty");
    check_counts("tog dirty", 6, 8);

    // Reset in the middle of a refill: read 146 evicts clean way1 (114).
    log_q.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_rw   = 1'b0;
    bus.cpu_addr = 10'd146;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_rw) seen = 1'b1;
    end
    check("rst mid refill reached", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    check("rst mid refill mem_req", int'(bus.mem_req), 0);
    check("rst mid refill mem_addr", 32'(bus.mem_addr), 0);
    check_counts("rst mid refill", 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(0, 114, 0, mv(114), "post rst 114", lat);
    check("post rst 114 latency", lat, 4);
    check_log("post rst 114", 0, 0, 0, 2, 114);
    @(negedge clk);
    check_counts("post rst 114", 0, 1);
    do_access(0, 115, 0, mv(115), "post rst 115", lat);
    check("post rst 115 latency", lat, 1);
    @(negedge clk);
    check_counts("post rst 115", 1, 1);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
